dvs_cdma: RTL and testbench
===========================

# dvs_cdma

Per-pixel temporal-contrast event generator for a parallel camera interface. It captures 8-bit pixels on `pclk` and fetches the stored reference pixels for the current line from a single-port 32-bit BRAM. It compares each new pixel against its reference with a programmable threshold, then writes back the updated reference line and a per-pixel event line. It sits between the camera front end and a CDMA engine, which it drives with per-frame and per-line pulses to move lines between BRAM and DDR.

## Interface
- No parameters. Fixed: 8-bit pixels, 4 pixels per 32-bit BRAM word, 17-bit byte address.
- Reference region base: `0x00000`. Event region base: `0x10000`.
- `pclk` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `vsync` in 1: frame sync; a rising edge starts a frame.
- `href` in 1: line valid; high for the whole line.
- `pix_data` in 8: pixel value.
- `write_enable_in` in 1: pixel strobe; `pix_data` is captured when `href=1` and `write_enable_in=1`.
- `threshold` in 8: contrast threshold, unsigned.
- `new_frame` out 1: one-cycle pulse on a frame start.
- `read_new_line` out 1: one-cycle pulse requesting that CDMA load the next reference line into BRAM.
- `write_new_line` out 1: one-cycle pulse requesting that CDMA store the finished reference and event lines.
- `bram_addr` out 17: byte address, always word aligned (bits [1:0]=0).
- `bram_clk` out 1: equals `pclk`.
- `bram_wrdata` out 32: write data.
- `bram_rddata` in 32: read data, valid one cycle after a read is issued.
- `bram_en` out 1: access enable.
- `bram_rst` out 1: active-high BRAM reset, equal to `~reset`.
- `bram_we` out 4: byte write enables; `0000` means a read.

## Operation
- Pixel packing: pixel k of a word (k=0..3, capture order) occupies byte k, bits [8k+7:8k].
- Word index w restarts at 0 on each `href` rise.
- Reference word address: `4w`. Event word address: `0x10000 + 4w`. Addresses wrap at `0xFFFC`.
- Capture: pixels go into a 4-byte buffer. The buffer is double-buffered, so the next word's pixels can be captured while the previous word is being processed.
- Comparison, per byte, with `p` = new pixel and `r` = reference byte:
  - ON: `p - r > threshold`; event byte `0x01`.
  - OFF: `r - p > threshold`; event byte `0x02`.
  - Otherwise: event byte `0x00`.
  - The comparison is strict and uses 9-bit signed arithmetic.
- Reference update: on an event the reference byte becomes `p`; otherwise it keeps `r`.
- FSM states and transitions:
  - IDLE → RD when a word is complete.
  - RD: issues the read of the reference word; goes to WR_REF.
  - WR_REF: compares against `bram_rddata` and writes the updated reference word; goes to WR_EVT.
  - WR_EVT: writes the event word and increments w; goes to IDLE, or to RD if another word is pending.
- Partial word at the `href` fall (fewer than 4 pixels captured): the word is flushed. `bram_we` enables only the captured bytes in both writes.
- Line end: `write_new_line` and `read_new_line` pulse together, one cycle after the final WR_EVT. If no word is pending, they pulse the cycle after the `href` fall.
- Frame start (`vsync` rise):
  - `new_frame` pulses.
  - w, the buffers and the FSM are cleared; any in-flight word is discarded.
  - `read_new_line` pulses in the next cycle to fetch line 0's reference.
- `bram_en` is 1 only in RD, WR_REF and WR_EVT. `bram_we=0000` in RD.

## Timing
- Reset (`reset=0` at a clock edge):
  - All outputs 0 except `bram_rst=1`.
  - FSM goes to IDLE; w, buffers and edge detectors clear.
  - Reset asserted mid-line discards the line.
- Capturing the 4th pixel at edge t gives:
  - RD in cycle t+1.
  - WR_REF (reference written) in cycle t+2.
  - WR_EVT (events written) in cycle t+3.
- Minimum supported pixel spacing: 2 clocks, which leaves ≥8 cycles per word for ≤3 port cycles.
- `new_frame` is asserted in the cycle after the edge at which `vsync` is first sampled high.
- `href` falling while a word is in process: processing completes, then the partial word (if any) is flushed, then the line-end pulses fire.

## Structure
- Shared package: state enum (IDLE, RD, WR_REF, WR_EVT), `EVT_NONE=8'h00`, `EVT_ON=8'h01`, `EVT_OFF=8'h02`, `REF_BASE`, `EVT_BASE`.
- One sub-module, `dvs_pixel_cmp`: combinational, takes (p, r, threshold) and returns (event byte, new reference byte); instantiated 4×.

## Test plan
- Reset held low → `bram_rst=1`, `bram_en=0`, all pulses 0, `bram_addr=0`.
- `vsync` pulse → one-cycle `new_frame`, then one-cycle `read_new_line`.
- `threshold=12`, `bram_rddata=0`, pixels 10,20,30,40 → read at `0x00000`, write `0x28_1E_14_00` with `we=1111`, then write `0x01_01_01_00` at `0x10000`.
- Same stimulus repeated 4 words → addresses step `0x0,0x4,0x8,0xC` and `0x10000..0x1000C`, identical data each word.
- `bram_rddata=0x28282828`, pixels 10,40,45,60, `threshold=12` → reference `0x3C_28_28_0A`, events `0x01_00_00_02`.
- 2 pixels then `href` fall → both writes with `we=0011`, then `write_new_line` and `read_new_line` together one cycle after WR_EVT.

Source files
------------

// File: rtl/dvs_cdma_pkg.sv
// Shared types and constants for the dvs_cdma temporal-contrast event generator.
// Word index width follows from the 16-bit per-region byte span (4 bytes per word).
package dvs_cdma_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD     = 2'd1,
      WR_REF = 2'd2,
      WR_EVT = 2'd3
   } state_t;

   localparam logic [7:0]  EVT_NONE   = 8'h00;
   localparam logic [7:0]  EVT_ON     = 8'h01;
   localparam logic [7:0]  EVT_OFF    = 8'h02;
   localparam logic [16:0] REF_BASE   = 17'h00000;
   localparam logic [16:0] EVT_BASE   = 17'h10000;
   localparam int          WORD_IDX_W = 14;

   // Word index to byte address; a 14-bit index makes the offset wrap at 0xFFFC.
   function automatic logic [16:0] word_addr(input logic [16:0] base,
                                             input logic [WORD_IDX_W-1:0] w);
      return base | {1'b0, w, 2'b00};
   endfunction

endpackage

// File: rtl/dvs_pixel_cmp.sv
// Single-pixel contrast comparator: classifies a new pixel against its reference
// and returns the event byte together with the updated reference byte.
module dvs_pixel_cmp
   import dvs_cdma_pkg::*;
(
   input  logic [7:0] p,
   input  logic [7:0] r,
   input  logic [7:0] threshold,
   output logic [7:0] evt,
   output logic [7:0] ref_new
);

   logic signed [8:0] diff_on_s;
   logic signed [8:0] diff_off_s;
   logic signed [8:0] thr_s;

   // Strict comparison in 9-bit signed arithmetic, both polarities.
   always_comb begin
      diff_on_s  = $signed({1'b0, p}) - $signed({1'b0, r});
      diff_off_s = $signed({1'b0, r}) - $signed({1'b0, p});
      thr_s      = $signed({1'b0, threshold});
      if (diff_on_s > thr_s) begin
         evt     = EVT_ON;
         ref_new = p;
      end else if (diff_off_s > thr_s) begin
         evt     = EVT_OFF;
         ref_new = p;
      end else begin
         evt     = EVT_NONE;
         ref_new = r;
      end
   end

endmodule

// File: rtl/dvs_cdma.sv
// Per-pixel temporal-contrast event generator: packs camera pixels into BRAM words,
// compares them against the stored reference line and writes back reference and events.
module dvs_cdma
   import dvs_cdma_pkg::*;
(
   input  logic        pclk,
   input  logic        reset,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  pix_data,
   input  logic        write_enable_in,
   input  logic [7:0]  threshold,
   output logic        new_frame,
   output logic        read_new_line,
   output logic        write_new_line,
   output logic [16:0] bram_addr,
   output logic        bram_clk,
   output logic [31:0] bram_wrdata,
   input  logic [31:0] bram_rddata,
   output logic        bram_en,
   output logic        bram_rst,
   output logic [3:0]  bram_we
);

   state_t                state_r;
   state_t                state_nxt_s;
   logic                  href_d_r;
   logic                  vsync_d_r;
   logic [31:0]           fill_data_r;
   logic [1:0]            fill_cnt_r;
   logic                  pend_valid_r;
   logic [31:0]           pend_data_r;
   logic [3:0]            pend_mask_r;
   logic [31:0]           work_data_r;
   logic [3:0]            work_mask_r;
   logic [31:0]           evt_word_r;
   logic [WORD_IDX_W-1:0] w_r;
   logic                  eol_r;
   logic                  new_frame_r;
   logic                  read_new_line_r;
   logic                  write_new_line_r;

   logic                  capture_s;
   logic                  href_rise_s;
   logic                  href_fall_s;
   logic                  vsync_rise_s;
   logic                  word_done_s;
   logic                  new_word_s;
   logic                  take_s;
   logic                  line_end_s;
   logic [31:0]           new_data_s;
   logic [3:0]            new_mask_s;
   logic [31:0]           ref_word_s;
   logic [31:0]           evt_word_s;

   assign bram_clk       = pclk;
   assign bram_rst       = ~reset;
   assign new_frame      = new_frame_r;
   assign read_new_line  = read_new_line_r;
   assign write_new_line = write_new_line_r;

   assign capture_s    = href & write_enable_in;
   assign href_rise_s  = href & ~href_d_r;
   assign href_fall_s  = ~href & href_d_r;
   assign vsync_rise_s = vsync & ~vsync_d_r;
   assign word_done_s  = capture_s & (fill_cnt_r == 2'd3);
   assign new_word_s   = word_done_s | (href_fall_s & (fill_cnt_r != 2'd0));
   assign line_end_s   = (eol_r | href_fall_s) & (state_nxt_s == IDLE);

   for (genvar k = 0; k < 4; k++) begin : g_cmp
      dvs_pixel_cmp u_cmp (
         .p         (work_data_r[8*k +: 8]),
         .r         (bram_rddata[8*k +: 8]),
         .threshold (threshold),
         .evt       (evt_word_s[8*k +: 8]),
         .ref_new   (ref_word_s[8*k +: 8])
      );
   end

   // Word being handed to the processing pipe: buffer plus the pixel arriving now.
   always_comb begin
      new_data_s = fill_data_r;
      new_mask_s = 4'b0000;
      if (capture_s) begin
         new_data_s[{fill_cnt_r, 3'b000} +: 8] = pix_data;
      end else begin
         new_data_s = fill_data_r;
      end
      if (word_done_s) begin
         new_mask_s = 4'b1111;
      end else begin
         case (fill_cnt_r)
            2'd1:    new_mask_s = 4'b0001;
            2'd2:    new_mask_s = 4'b0011;
            2'd3:    new_mask_s = 4'b0111;
            default: new_mask_s = 4'b0000;
         endcase
      end
   end

   // Next-state logic; a queued word is taken from IDLE or straight out of WR_EVT.
   always_comb begin
      state_nxt_s = state_r;
      take_s      = 1'b0;
      case (state_r)
         IDLE, WR_EVT: begin
            if (pend_valid_r | new_word_s) begin
               state_nxt_s = RD;
               take_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RD:      state_nxt_s = WR_REF;
         WR_REF:  state_nxt_s = WR_EVT;
         default: state_nxt_s = IDLE;
      endcase
   end

   // BRAM port decode from the current state.
   always_comb begin
      bram_en     = 1'b0;
      bram_we     = 4'b0000;
      bram_addr   = 17'h00000;
      bram_wrdata = 32'h00000000;
      case (state_r)
         RD: begin
            bram_en   = 1'b1;
            bram_addr = word_addr(REF_BASE, w_r);
         end
         WR_REF: begin
            bram_en     = 1'b1;
            bram_we     = work_mask_r;
            bram_addr   = word_addr(REF_BASE, w_r);
            bram_wrdata = ref_word_s;
         end
         WR_EVT: begin
            bram_en     = 1'b1;
            bram_we     = work_mask_r;
            bram_addr   = word_addr(EVT_BASE, w_r);
            bram_wrdata = evt_word_r;
         end
         default: begin
            bram_en = 1'b0;
         end
      endcase
   end

   // Edge detectors and CDMA handshake pulses.
   always_ff @(posedge pclk) begin
      if (!reset) begin
         href_d_r         <= 1'b0;
         vsync_d_r        <= 1'b0;
         new_frame_r      <= 1'b0;
         read_new_line_r  <= 1'b0;
         write_new_line_r <= 1'b0;
         eol_r            <= 1'b0;
      end else begin
         href_d_r         <= href;
         vsync_d_r        <= vsync;
         new_frame_r      <= vsync_rise_s;
         read_new_line_r  <= new_frame_r | (line_end_s & ~vsync_rise_s);
         write_new_line_r <= line_end_s & ~vsync_rise_s;
         eol_r            <= (eol_r | href_fall_s) & ~line_end_s & ~vsync_rise_s;
      end
   end

   // Capture buffer, pending/working word slots, FSM state and word index.
   always_ff @(posedge pclk) begin
      if (!reset || vsync_rise_s) begin
         state_r      <= IDLE;
         fill_data_r  <= 32'h00000000;
         fill_cnt_r   <= 2'd0;
         pend_valid_r <= 1'b0;
         pend_data_r  <= 32'h00000000;
         pend_mask_r  <= 4'b0000;
         work_data_r  <= 32'h00000000;
         work_mask_r  <= 4'b0000;
         evt_word_r   <= 32'h00000000;
         w_r          <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (word_done_s || href_fall_s) begin
            fill_data_r <= 32'h00000000;
            fill_cnt_r  <= 2'd0;
         end else if (capture_s) begin
            fill_data_r <= new_data_s;
            fill_cnt_r  <= fill_cnt_r + 2'd1;
         end else begin
            fill_data_r <= fill_data_r;
         end
         if (take_s && pend_valid_r) begin
            work_data_r  <= pend_data_r;
            work_mask_r  <= pend_mask_r;
            pend_valid_r <= new_word_s;
            pend_data_r  <= new_data_s;
            pend_mask_r  <= new_mask_s;
         end else if (take_s) begin
            work_data_r <= new_data_s;
            work_mask_r <= new_mask_s;
         end else if (new_word_s) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= new_data_s;
            pend_mask_r  <= new_mask_s;
         end else begin
            pend_valid_r <= pend_valid_r;
         end
         if (state_r == WR_REF) begin
            evt_word_r <= evt_word_s;
         end else begin
            evt_word_r <= evt_word_r;
         end
         if (href_rise_s) begin
            w_r <= '0;
         end else if (state_r == WR_EVT) begin
            w_r <= w_r + 14'd1;
         end else begin
            w_r <= w_r;
         end
      end
   end

endmodule

// File: tb/tb_dvs_cdma.sv
// Self-checking bench for dvs_cdma: table-driven word vectors with a BRAM access
// scoreboard, plus hand-timed sequences for reset, frame start and line end.
module tb_dvs_cdma;

   logic        pclk = 1'b0;
   logic        reset;
   logic        vsync;
   logic        href;
   logic [7:0]  pix_data;
   logic        write_enable_in;
   logic [7:0]  threshold;
   logic        new_frame;
   logic        read_new_line;
   logic        write_new_line;
   logic [16:0] bram_addr;
   logic        bram_clk;
   logic [31:0] bram_wrdata;
   logic [31:0] bram_rddata;
   logic        bram_en;
   logic        bram_rst;
   logic [3:0]  bram_we;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [16:0] addr;
      logic [3:0]  we;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      logic [7:0]  thr;
      logic [31:0] rd;
      logic [31:0] pix;
      logic [31:0] exp_ref;
      logic [31:0] exp_evt;
   } vec_t;

   txn_t sb_q[$];
   vec_t vecs[8];

   dvs_cdma dut (
      .pclk            (pclk),
      .reset           (reset),
      .vsync           (vsync),
      .href            (href),
      .pix_data        (pix_data),
      .write_enable_in (write_enable_in),
      .threshold       (threshold),
      .new_frame       (new_frame),
      .read_new_line   (read_new_line),
      .write_new_line  (write_new_line),
      .bram_addr       (bram_addr),
      .bram_clk        (bram_clk),
      .bram_wrdata     (bram_wrdata),
      .bram_rddata     (bram_rddata),
      .bram_en         (bram_en),
      .bram_rst        (bram_rst),
      .bram_we         (bram_we)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] bytemask(input logic [3:0] we);
      return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
   endfunction

   task automatic push_word(input logic [16:0] ref_addr, input logic [3:0] we,
                            input logic [31:0] rdat, input logic [31:0] edat);
      txn_t t;
      t.addr = ref_addr;           t.we = 4'b0000; t.data = 32'h0; sb_q.push_back(t);
      t.addr = ref_addr;           t.we = we;      t.data = rdat;  sb_q.push_back(t);
      t.addr = ref_addr | 17'h10000; t.we = we;    t.data = edat;  sb_q.push_back(t);
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic send_pixel(input logic [7:0] p);
      pix_data        = p;
      write_enable_in = 1'b1;
      tick();
      write_enable_in = 1'b0;
      tick();
   endtask

   // Scoreboard: every enabled BRAM cycle must match the next expected access.
   always @(negedge pclk) begin
      if (bram_en === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got access at %h, expected none", bram_addr);
         end else begin
            txn_t t;
            t = sb_q.pop_front();
            check("sb_addr", {15'h0, bram_addr}, {15'h0, t.addr});
            check("sb_we", {28'h0, bram_we}, {28'h0, t.we});
            check("sb_data", bram_wrdata & bytemask(t.we), t.data & bytemask(t.we));
         end
      end
   end

   initial begin
      logic [16:0] a;
      vecs[0] = '{thr: 8'd12,  rd: 32'h00000000, pix: 32'h281E140A, exp_ref: 32'h281E1400, exp_evt: 32'h01010100};
      vecs[1] = vecs[0];
      vecs[2] = vecs[0];
      vecs[3] = vecs[0];
      vecs[4] = '{thr: 8'd12,  rd: 32'h28282828, pix: 32'h3C2D280A, exp_ref: 32'h3C28280A, exp_evt: 32'h01000002};
      vecs[5] = '{thr: 8'd12,  rd: 32'h64646464, pix: 32'h57715870, exp_ref: 32'h57716464, exp_evt: 32'h02010000};
      vecs[6] = '{thr: 8'd0,   rd: 32'h00FF00FF, pix: 32'h0000FFFF, exp_ref: 32'h0000FFFF, exp_evt: 32'h00020100};
      vecs[7] = '{thr: 8'd255, rd: 32'h00000000, pix: 32'h00FF00FF, exp_ref: 32'h00000000, exp_evt: 32'h00000000};

      reset           = 1'b0;
      vsync           = 1'b0;
      href            = 1'b0;
      pix_data        = 8'h00;
      write_enable_in = 1'b0;
      threshold       = 8'd12;
      bram_rddata     = 32'h0;

      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("rst_bram_rst", {31'h0, bram_rst}, 32'h1);
      check("rst_bram_en", {31'h0, bram_en}, 32'h0);
      check("rst_new_frame", {31'h0, new_frame}, 32'h0);
      check("rst_read_line", {31'h0, read_new_line}, 32'h0);
      check("rst_write_line", {31'h0, write_new_line}, 32'h0);
      check("rst_addr", {15'h0, bram_addr}, 32'h0);
      check("rst_we", {28'h0, bram_we}, 32'h0);
      tick();
      reset = 1'b1;
      repeat (2) tick();

      // Frame start: new_frame then read_new_line, one cycle each.
      vsync = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      check("vs_new_frame_1", {31'h0, new_frame}, 32'h1);
      check("vs_read_line_1", {31'h0, read_new_line}, 32'h0);
      @(negedge pclk);
      check("vs_new_frame_2", {31'h0, new_frame}, 32'h0);
      check("vs_read_line_2", {31'h0, read_new_line}, 32'h1);
      @(negedge pclk);
      check("vs_new_frame_3", {31'h0, new_frame}, 32'h0);
      check("vs_read_line_3", {31'h0, read_new_line}, 32'h0);
      tick();
      vsync = 1'b0;
      tick();

      // Table-driven full words on one line, with per-word latency checks.
      href = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         threshold   = vecs[i].thr;
         bram_rddata = vecs[i].rd;
         a = 17'(4 * i);
         push_word(a, 4'b1111, vecs[i].exp_ref, vecs[i].exp_evt);
         for (int k = 0; k < 3; k++) send_pixel(vecs[i].pix[8*k +: 8]);
         pix_data        = vecs[i].pix[31:24];
         write_enable_in = 1'b1;
         @(posedge pclk);
         #1;
         write_enable_in = 1'b0;
         @(negedge pclk);
         check("t1_rd_en", {31'h0, bram_en}, 32'h1);
         check("t1_rd_we", {28'h0, bram_we}, 32'h0);
         check("t1_rd_addr", {15'h0, bram_addr}, {15'h0, a});
         @(negedge pclk);
         check("t2_ref_we", {28'h0, bram_we}, 32'hF);
         @(negedge pclk);
         check("t3_evt_addr", {15'h0, bram_addr}, {15'h0, a | 17'h10000});
         @(negedge pclk);
         check("t4_idle_en", {31'h0, bram_en}, 32'h0);
         tick();
      end

      // Line end with nothing pending: pulses the cycle after the href fall.
      href = 1'b0;
      @(posedge pclk);
      @(negedge pclk);
      check("eol_write_line", {31'h0, write_new_line}, 32'h1);
      check("eol_read_line", {31'h0, read_new_line}, 32'h1);
      @(negedge pclk);
      check("eol_write_line_off", {31'h0, write_new_line}, 32'h0);
      check("eol_read_line_off", {31'h0, read_new_line}, 32'h0);
      tick();

      // Partial word flushed at href fall, then line-end pulses after WR_EVT.
      threshold   = 8'd12;
      bram_rddata = 32'h0;
      href        = 1'b1;
      tick();
      push_word(17'h0, 4'b0011, 32'h00001400, 32'h00000100);
      send_pixel(8'd10);
      send_pixel(8'd20);
      href = 1'b0;
      @(posedge pclk);
      @(negedge pclk);
      check("pw_rd_en", {31'h0, bram_en}, 32'h1);
      check("pw_rd_we", {28'h0, bram_we}, 32'h0);
      check("pw_rd_write_line", {31'h0, write_new_line}, 32'h0);
      @(negedge pclk);
      check("pw_ref_we", {28'h0, bram_we}, 32'h3);
      @(negedge pclk);
      check("pw_evt_we", {28'h0, bram_we}, 32'h3);
      check("pw_evt_addr", {15'h0, bram_addr}, 32'h10000);
      check("pw_evt_write_line", {31'h0, write_new_line}, 32'h0);
      @(negedge pclk);
      check("pw_write_line", {31'h0, write_new_line}, 32'h1);
      check("pw_read_line", {31'h0, read_new_line}, 32'h1);
      check("pw_idle_en", {31'h0, bram_en}, 32'h0);
      @(negedge pclk);
      check("pw_write_line_off", {31'h0, write_new_line}, 32'h0);
      check("pw_read_line_off", {31'h0, read_new_line}, 32'h0);

      repeat (5) tick();
      check("sb_empty", sb_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
